wb_arbiter: RTL and testbench

- Shares the single ROB writeback port among NUM_REQ execution units: 0 = alu, 1 = div, 2 = mul, 3 = load.
- Each source pushes (ROB tag, result) into its own small FIFO.
- A round-robin scheduler drains one entry per cycle into a registered writeback bus.
- The bus drives the ROB dst_value/ready write, replacing the ROB's fixed priority chain.
- The ROB never back-pressures, so the arbiter is the only point of flow control.

---
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-source result FIFOs drained one per cycle onto a registered ROB writeback bus.
// Round-robin grant by default; define WB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          wb_valid,
  output logic [TAG_WIDTH-1:0]          wb_tag,
  output logic [DATA_WIDTH-1:0]         wb_data,
  output logic [SW-1:0]                 wb_src,
  output logic                          wb_busy
);
  logic [CW-1:0]         cnt_q [NUM_REQ];
  logic [CW-1:0]         cnt_d [NUM_REQ];
  logic [PW-1:0]         wptr_q [NUM_REQ];
  logic [PW-1:0]         wptr_d [NUM_REQ];
  logic [PW-1:0]         rptr_q [NUM_REQ];
  logic [PW-1:0]         rptr_d [NUM_REQ];
  logic [TAG_WIDTH-1:0]  tag_mem_q [NUM_REQ][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [NUM_REQ][FIFO_DEPTH];
  logic [NUM_REQ-1:0]    push;
  logic [NUM_REQ-1:0]    pop;
  logic                  gnt;
  logic [SW-1:0]         gnt_src;
  logic                  wb_valid_q, wb_valid_d;
  logic [TAG_WIDTH-1:0]  wb_tag_q, wb_tag_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [SW-1:0]         wb_src_q, wb_src_d;

  assign wb_valid = wb_valid_q;
  assign wb_tag   = wb_tag_q;
  assign wb_data  = wb_data_q;
  assign wb_src   = wb_src_q;

  // ready/busy come from registered counts; a full FIFO stays not-ready even while being popped
  always_comb begin
    wb_busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = cnt_q[i] != CW'(FIFO_DEPTH);
      wb_busy      = wb_busy | (cnt_q[i] != '0);
      push[i]      = req_valid[i] && req_ready[i] && !flush;
    end
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  // fixed priority: scan downwards so the lowest non-empty index is the last to claim the grant
  always_comb begin
    gnt     = 1'b0;
    gnt_src = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (cnt_q[k] != '0) begin
        gnt     = 1'b1;
        gnt_src = SW'(k);
      end
  end
`else
  logic [SW-1:0] rr_q, rr_d, idx;

  // round-robin: scan offsets from rr_q downwards so the nearest non-empty source wins
  always_comb begin
    gnt     = 1'b0;
    gnt_src = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = SW'((int'(rr_q) + k) % NUM_REQ);
      if (cnt_q[idx] != '0) begin
        gnt     = 1'b1;
        gnt_src = idx;
      end
    end
  end

  assign rr_d = (gnt && !flush) ? SW'((int'(gnt_src) + 1) % NUM_REQ) : rr_q;

  // rotating pointer survives flush so fairness is not reset by a mispredict
  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  // FIFO bookkeeping and next writeback beat; flush wipes queues and drops the pending grant
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i]    = gnt && !flush && (gnt_src == SW'(i));
      cnt_d[i]  = flush ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      wptr_d[i] = flush ? '0 : wptr_q[i] + PW'(push[i]);
      rptr_d[i] = flush ? '0 : rptr_q[i] + PW'(pop[i]);
    end
    wb_valid_d = gnt && !flush;
    wb_tag_d   = wb_valid_d ? tag_mem_q[gnt_src][rptr_q[gnt_src]] : wb_tag_q;
    wb_data_d  = wb_valid_d ? data_mem_q[gnt_src][rptr_q[gnt_src]] : wb_data_q;
    wb_src_d   = wb_valid_d ? gnt_src : wb_src_q;
  end

  // control state and the registered writeback bus
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_tag_q   <= '0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i]  <= cnt_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
      end
      wb_valid_q <= wb_valid_d;
      wb_tag_q   <= wb_tag_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
    end
  end

  // entry storage needs no reset: counts decide what is visible
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (push[i] && !rst) begin
        tag_mem_q[i][wptr_q[i]]  <= req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        data_mem_q[i][wptr_q[i]] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
    assert property (@(posedge clk) disable iff (rst) !(req_valid[i] && !req_ready[i]));
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of the writeback arbiter
module tb_wb_arbiter;
  localparam int N = 4;
  localparam int TW = 5;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_data = '0;
  logic wb_valid;
  logic [TW-1:0] wb_tag;
  logic [DW-1:0] wb_data;
  logic [1:0] wb_src;
  logic wb_busy;
  int vecs = 0;
  int errs = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_data(req_data),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_src(wb_src), .wb_busy(wb_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] dat(input logic [TW-1:0] t);
    return 32'hC0DE_0000 + {27'd0, t};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int s, input logic [TW-1:0] t);
    req_valid[s] = 1'b1;
    req_tag[s*TW +: TW] = t;
    req_data[s*DW +: DW] = dat(t);
  endtask

  task automatic do_reset();
    req_valid = '0;
    flush = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if ({wb_valid, wb_tag, wb_data, wb_src, wb_busy} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got v=%0b tag=%0d data=%h src=%0d busy=%0b, want all 0", wb_valid, wb_tag, wb_data, wb_src, wb_busy);
    end
    vecs++;
    if (req_ready !== 4'hF) begin errs++; $display("FAIL reset_ready: got %b want 1111", req_ready); end
    put(0, 5);
    req_data[31:0] = 32'hDEADBEEF;
    step();
    req_valid = '0;
    vecs++;
    if (wb_valid !== 1'b0 || wb_busy !== 1'b1) begin
      errs++;
      $display("FAIL single_accept: got v=%0b busy=%0b want v=0 busy=1", wb_valid, wb_busy);
    end
    step();
    vecs++;
    if (wb_valid !== 1'b1 || wb_tag !== 5'd5 || wb_data !== 32'hDEADBEEF || wb_src !== 2'd0) begin
      errs++;
      $display("FAIL single_wb: got v=%0b tag=%0d data=%h src=%0d want 1 5 deadbeef 0", wb_valid, wb_tag, wb_data, wb_src);
    end
    vecs++;
    if (wb_busy !== 1'b0) begin errs++; $display("FAIL single_busy: got %0b want 0", wb_busy); end
    step();
    vecs++;
    if (wb_valid !== 1'b0 || wb_tag !== 5'd5 || wb_src !== 2'd0) begin
      errs++;
      $display("FAIL single_hold: got v=%0b tag=%0d src=%0d want 0 5 0", wb_valid, wb_tag, wb_src);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    put(0, 7);
    put(3, 8);
    step();
    rst = 1'b1;
    put(1, 9);
    step();
    rst = 1'b0;
    req_valid = '0;
    vecs++;
    if (wb_valid !== 1'b0 || wb_tag !== 5'd0 || wb_busy !== 1'b0 || req_ready !== 4'hF) begin
      errs++;
      $display("FAIL reset_mid: got v=%0b tag=%0d busy=%0b rdy=%b want 0 0 0 1111", wb_valid, wb_tag, wb_busy, req_ready);
    end
    step();
    step();
    vecs++;
    if (wb_valid !== 1'b0 || wb_busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_drop: got v=%0b busy=%0b want 0 0", wb_valid, wb_busy);
    end
  endtask

  task automatic test_all_four();
    do_reset();
    for (int s = 0; s < 4; s++) put(s, 5'(s + 1));
    step();
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      vecs++;
      if (wb_valid !== 1'b1 || wb_src !== 2'(k) || wb_tag !== 5'(k + 1) || wb_data !== dat(5'(k + 1))) begin
        errs++;
        $display("FAIL all_four[%0d]: got v=%0b src=%0d tag=%0d want 1 %0d %0d", k, wb_valid, wb_src, wb_tag, k, k + 1);
      end
    end
    step();
    vecs++;
    if (wb_valid !== 1'b0 || wb_busy !== 1'b0) begin
      errs++;
      $display("FAIL all_four_idle: got v=%0b busy=%0b want 0 0", wb_valid, wb_busy);
    end
  endtask

  task automatic test_fairness();
    logic ev[7];
    logic [1:0] es[7];
    logic [TW-1:0] et[7];
    logic r2;
    logic [TW-1:0] t;
`ifdef WB_ARB_FIXED_PRIO_EN
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    es = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
    et = '{5'd0, 5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd0};
    r2 = 1'b1;
`else
    ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    es = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    et = '{5'd0, 5'd10, 5'd20, 5'd11, 5'd12, 5'd0, 5'd0};
    r2 = 1'b0;
`endif
    do_reset();
    t = 5'd10;
    for (int c = 0; c < 7; c++) begin
      req_valid = '0;
      if (c < 4 && req_ready[0]) begin
        put(0, t);
        t++;
      end
      if (c == 0) put(2, 5'd20);
      step();
      vecs++;
      if (wb_valid !== ev[c] || (ev[c] && (wb_src !== es[c] || wb_tag !== et[c] || wb_data !== dat(et[c])))) begin
        errs++;
        $display("FAIL fairness[%0d]: got v=%0b src=%0d tag=%0d want v=%0b src=%0d tag=%0d", c, wb_valid, wb_src, wb_tag, ev[c], es[c], et[c]);
      end
      if (c == 2) begin
        vecs++;
        if (req_ready[0] !== r2) begin errs++; $display("FAIL fairness_ready: got %0b want %0b", req_ready[0], r2); end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_full();
    logic ev[7];
    logic [1:0] es[7];
    logic [TW-1:0] et[7];
`ifdef WB_ARB_FIXED_PRIO_EN
    es = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
    et = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0};
`else
    es = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1, 2'd0};
    et = '{5'd1, 5'd2, 5'd5, 5'd6, 5'd3, 5'd4, 5'd0};
`endif
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req_valid = '0;
      if (c == 0) begin
        put(0, 5'd1);
        put(1, 5'd2);
        put(2, 5'd5);
        put(3, 5'd6);
      end
      if (c == 1) put(1, 5'd3);
      if (c == 3 && req_ready[1]) put(1, 5'd4);
      step();
      if (c >= 1) begin
        vecs++;
        if (wb_valid !== ev[c-1] || (ev[c-1] && (wb_src !== es[c-1] || wb_tag !== et[c-1] || wb_data !== dat(et[c-1])))) begin
          errs++;
          $display("FAIL full[%0d]: got v=%0b src=%0d tag=%0d want v=%0b src=%0d tag=%0d", c, wb_valid, wb_src, wb_tag, ev[c-1], es[c-1], et[c-1]);
        end
      end
      if (c == 1 || c == 2) begin
        vecs++;
        if (req_ready[1] !== (c == 2)) begin
          errs++;
          $display("FAIL full_ready[%0d]: got %0b want %0b", c, req_ready[1], c == 2);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_flush();
    do_reset();
    put(0, 5'd1);
    put(3, 5'd2);
    step();
    req_valid = '0;
    put(0, 5'd3);
    put(3, 5'd4);
    step();
    req_valid = '0;
    vecs++;
    if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_tag !== 5'd1 || wb_busy !== 1'b1 || req_ready !== 4'b0111) begin
      errs++;
      $display("FAIL flush_pre: got v=%0b src=%0d tag=%0d busy=%0b rdy=%b want 1 0 1 1 0111", wb_valid, wb_src, wb_tag, wb_busy, req_ready);
    end
    flush = 1'b1;
    put(2, 5'd9);
    step();
    flush = 1'b0;
    req_valid = '0;
    vecs++;
    if (wb_valid !== 1'b0 || wb_busy !== 1'b0 || req_ready !== 4'hF) begin
      errs++;
      $display("FAIL flush_clear: got v=%0b busy=%0b rdy=%b want 0 0 1111", wb_valid, wb_busy, req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      vecs++;
      if (wb_valid !== 1'b0) begin errs++; $display("FAIL flush_drop[%0d]: got v=%0b want 0", c, wb_valid); end
    end
    put(0, 5'd10);
    put(1, 5'd11);
    step();
    req_valid = '0;
    step();
    vecs++;
`ifdef WB_ARB_FIXED_PRIO_EN
    if (wb_valid !== 1'b1 || wb_src !== 2'd0 || wb_tag !== 5'd10) begin
      errs++;
      $display("FAIL flush_prio: got v=%0b src=%0d tag=%0d want 1 0 10", wb_valid, wb_src, wb_tag);
    end
`else
    if (wb_valid !== 1'b1 || wb_src !== 2'd1 || wb_tag !== 5'd11) begin
      errs++;
      $display("FAIL flush_rr_held: got v=%0b src=%0d tag=%0d want 1 1 11", wb_valid, wb_src, wb_tag);
    end
`endif
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req_valid = '0;
      if (c < 10) put(3, 5'(c + 12));
      step();
      vecs++;
      if (c >= 1 && c <= 10) begin
        if (wb_valid !== 1'b1 || wb_src !== 2'd3 || wb_tag !== 5'(c + 11) || wb_data !== dat(5'(c + 11)) || req_ready[3] !== 1'b1) begin
          errs++;
          $display("FAIL wrap[%0d]: got v=%0b src=%0d tag=%0d rdy=%0b want 1 3 %0d 1", c, wb_valid, wb_src, wb_tag, req_ready[3], c + 11);
        end
      end else if (wb_valid !== 1'b0) begin
        errs++;
        $display("FAIL wrap_idle[%0d]: got v=%0b want 0", c, wb_valid);
      end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_all_four();
    test_fairness();
    test_full();
    test_flush();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
